// File: rtl/quad_encoder_bank.sv
// quad_encoder_bank
//   N-channel quadrature encoder counter with illegal-transition detection
//   and a one-cycle read port.
//
//   Optional feature macro: QENC_DEBOUNCE_EN
//     When defined, every synchronised pin passes through a glitch filter that
//     follows its input only after DEB_CYC consecutive differing samples.
//     Pin-to-count latency is then 3+DEB_CYC cycles instead of 3.
//
//   Parameters
//     NCH       number of channels (1..8)
//     CW        counter width, two's-complement signed
//     SATURATE  0: wrap modulo 2^CW, 1: clamp at the signed limits
//     DEB_CYC   glitch filter length in cycles (>=1, debounce build only)
//
//   Ports
//     wb_clk_i   system clock
//     wb_rst_i   synchronous reset, active-high
//     enc_a      phase A per channel (asynchronous)
//     enc_b      phase B per channel (asynchronous)
//     clr        per-channel counter clear pulse
//     rd_stb     read request pulse
//     rd_sel     channel to read
//     rd_valid   read data valid pulse, one cycle after rd_stb
//     rd_count   counter of the selected channel, sampled at rd_stb
//     rd_err     sticky illegal-transition flag of the selected channel
module quad_encoder_bank #(
    parameter int NCH      = 3,
    parameter int CW       = 16,
    parameter int SATURATE = 0,
    parameter int DEB_CYC  = 4
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic [NCH-1:0] enc_a,
    input  logic [NCH-1:0] enc_b,
    input  logic [NCH-1:0] clr,
    input  logic           rd_stb,
    input  logic [2:0]     rd_sel,
    output logic           rd_valid,
    output logic [CW-1:0]  rd_count,
    output logic           rd_err
);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } step_e;

    localparam int unsigned NPIN = 2 * NCH;
    localparam logic [CW-1:0] CNT_MAX = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] CNT_MIN = {1'b1, {(CW-1){1'b0}}};

    // Pin vector layout: [NCH-1:0] are the A phases, [2*NCH-1:NCH] the B phases.
    logic [NPIN-1:0] sync1_q;
    logic [NPIN-1:0] sync2_q;
    logic [NPIN-1:0] pin_v;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {enc_b, enc_a};
            sync2_q <= sync1_q;
        end
    end

`ifdef QENC_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    // Warm-up also covers the filter settling onto pins held steady through reset.
    localparam int WARM  = 2 + DEB_CYC;

    logic [NPIN-1:0]  filt_q;
    logic [DEB_W-1:0] deb_q [NPIN];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < NPIN; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NPIN; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    deb_q[i]  <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end

    assign pin_v = filt_q;
`else
    // DEB_CYC only matters to the debounce build; referenced here so both
    // builds share one parameter list.
    localparam int WARM = 2 + 0 * DEB_CYC;

    assign pin_v = sync2_q;
`endif

    // The synchroniser holds reset zeros for its first two cycles; priming is
    // deferred until it (and the filter, if present) carries real pin data so
    // that pins held high through reset release are not seen as a jump.
    localparam int WW = $clog2(WARM + 1);

    logic [WW-1:0] warm_q;
    logic          primed_q;
    logic [1:0]    cur_s  [NCH];
    logic [1:0]    prev_q [NCH];
    step_e         step   [NCH];
    logic [CW-1:0] cnt_q  [NCH];
    logic [NCH-1:0] err_q;
    logic [CW-1:0] sel_cnt;
    logic          sel_err;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cur_s[i] = {pin_v[i], pin_v[NCH+i]};
            step[i]  = STEP_NONE;
            if (primed_q && cur_s[i] != prev_q[i]) begin
                case ({prev_q[i], cur_s[i]})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step[i] = STEP_FWD;
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step[i] = STEP_REV;
                    default:                                 step[i] = STEP_ILL;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            warm_q   <= '0;
            primed_q <= 1'b0;
            err_q    <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                prev_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            if (!primed_q) begin
                if (warm_q == WW'(WARM)) begin
                    primed_q <= 1'b1;
                end else begin
                    warm_q <= warm_q + 1'b1;
                end
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                prev_q[i] <= cur_s[i];

                if (clr[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    case (step[i])
                        STEP_FWD: begin
                            if (!(SATURATE != 0 && cnt_q[i] == CNT_MAX)) begin
                                cnt_q[i] <= cnt_q[i] + CW'(1);
                            end
                        end
                        STEP_REV: begin
                            if (!(SATURATE != 0 && cnt_q[i] == CNT_MIN)) begin
                                cnt_q[i] <= cnt_q[i] - CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end

                // A new illegal transition outranks the read-side clear.
                if (step[i] == STEP_ILL) begin
                    err_q[i] <= 1'b1;
                end else if (rd_stb && rd_sel == 3'(i)) begin
                    err_q[i] <= 1'b0;
                end
            end
        end
    end

    // Out-of-range selects fall through to zeros.
    always_comb begin
        sel_cnt = '0;
        sel_err = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rd_sel == 3'(i)) begin
                sel_cnt = cnt_q[i];
                sel_err = err_q[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_valid <= 1'b0;
            rd_count <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_stb;
            if (rd_stb) begin
                rd_count <= sel_cnt;
                rd_err   <= sel_err;
            end
        end
    end

endmodule
